// File: rtl/prog_counter.sv
// Programmable up/down counter over the range [0, lim] with wrap or saturate
// behaviour at the terminal value, a registered wrap pulse and a saturation flag.
module prog_counter #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         ld,
  input  logic [N-1:0] initld,
  input  logic         up,
  input  logic [N-1:0] lim,
  input  logic         sat,
  output logic [N-1:0] out,
  output logic         co,
  output logic         tc,
  output logic         hold
);

  localparam logic [N-1:0] ONE_VAL = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] term_val;
  logic [N-1:0] step_val;
  logic [N-1:0] wrap_val;
  logic         at_end;

  // Counting up, anything at or above lim is treated as end-of-range so an
  // out-of-range load recovers on the next step. Counting down, a value above
  // lim simply decrements back into range; only 0 is the end.
  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    term_val = up ? lim : '0;
    wrap_val = up ? '0 : lim;
    step_val = up ? (out + ONE_VAL) : (out - ONE_VAL);
    at_end   = up ? (out >= lim) : (out == '0);
  end

  assign tc = (out == term_val);

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      out  <= '0;
      co   <= 1'b0;
      hold <= 1'b0;
    end else if (ld) begin
      out  <= initld;
      co   <= 1'b0;
      hold <= 1'b0;
    end else if (en) begin
      if (!at_end) begin
        out  <= step_val;
        co   <= 1'b0;
        hold <= 1'b0;
      end else if (sat) begin
        out  <= term_val;
        co   <= 1'b0;
        hold <= 1'b1;
      end else begin
        out  <= wrap_val;
        co   <= 1'b1;
        hold <= 1'b0;
      end
    end else begin
      // co is a one-cycle pulse; the count and saturation flag are kept.
      co <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
// Directed, table-driven bench for prog_counter: an N=4 instance driven from a
// vector table, plus an N=6 instance run as a free-running modulo-64 counter.
module tb_prog_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=4 instance
  logic       rst, en, ld, up, sat;
  logic [3:0] initld, lim;
  logic [3:0] out;
  logic       co, tc, hold;

  prog_counter #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .initld(initld), .up(up),
    .lim(lim), .sat(sat), .out(out), .co(co), .tc(tc), .hold(hold)
  );

  // N=6 instance
  logic       rst6, en6, ld6, up6, sat6;
  logic [5:0] initld6, lim6;
  logic [5:0] out6;
  logic       co6, tc6, hold6;

  prog_counter #(.N(6)) dut6 (
    .clk(clk), .rst(rst6), .en(en6), .ld(ld6), .initld(initld6), .up(up6),
    .lim(lim6), .sat(sat6), .out(out6), .co(co6), .tc(tc6), .hold(hold6)
  );

  typedef struct {
    string      name;
    logic       rst, ld, en, up, sat;
    logic [3:0] initld, lim;
    logic [3:0] exp_out;
    logic       exp_co, exp_hold, exp_tc;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic add(input string name, input logic r, input logic l, input logic e,
                     input logic u, input logic s, input logic [3:0] il, input logic [3:0] lm,
                     input logic [3:0] eo, input logic ec, input logic eh, input logic et);
    vec_t v;
    v.name = name; v.rst = r; v.ld = l; v.en = e; v.up = u; v.sat = s;
    v.initld = il; v.lim = lm; v.exp_out = eo; v.exp_co = ec; v.exp_hold = eh; v.exp_tc = et;
    vecs.push_back(v);
  endtask

  initial begin
    int co_pulses;
    int exp6;

    rst = 1'b1; en = 1'b0; ld = 1'b0; up = 1'b1; sat = 1'b0; initld = '0; lim = 4'd9;
    rst6 = 1'b1; en6 = 1'b0; ld6 = 1'b0; up6 = 1'b1; sat6 = 1'b0; initld6 = '0; lim6 = 6'd63;

    //   name        rst ld en up sat init lim  out co hold tc
    add("reset",      1, 0, 0, 1, 0,  0,   9,   0,  0, 0,   0);
    // count 0..9 then wrap to 0 with one co pulse
    for (int i = 1; i <= 9; i++)
      add("wrap_up",  0, 0, 1, 1, 0,  0,   9,   4'(i), 0, 0, (i == 9) ? 1'b1 : 1'b0);
    add("wrap_up_0",  0, 0, 1, 1, 0,  0,   9,   0,  1, 0,   0);
    add("wrap_up_1",  0, 0, 1, 1, 0,  0,   9,   1,  0, 0,   0);
    // saturate at 9 from 7, then reverse direction
    add("sat_ld7",    0, 1, 0, 1, 1,  7,   9,   7,  0, 0,   0);
    add("sat_8",      0, 0, 1, 1, 1,  0,   9,   8,  0, 0,   0);
    add("sat_9",      0, 0, 1, 1, 1,  0,   9,   9,  0, 0,   1);
    add("sat_hold_a", 0, 0, 1, 1, 1,  0,   9,   9,  0, 1,   1);
    add("sat_hold_b", 0, 0, 1, 1, 1,  0,   9,   9,  0, 1,   1);
    add("sat_down",   0, 0, 1, 0, 1,  0,   9,   8,  0, 0,   0);
    // down-count wrap from 0 to lim
    add("dn_ld1",     0, 1, 0, 0, 0,  1,   9,   1,  0, 0,   0);
    add("dn_0",       0, 0, 1, 0, 0,  0,   9,   0,  0, 0,   1);
    add("dn_wrap9",   0, 0, 1, 0, 0,  0,   9,   9,  1, 0,   0);
    add("dn_8",       0, 0, 1, 0, 0,  0,   9,   8,  0, 0,   0);
    // load beats enable; out-of-range load then step
    add("oor_ld12w",  0, 1, 1, 1, 0, 12,   9,  12,  0, 0,   0);
    add("oor_wrap",   0, 0, 1, 1, 0,  0,   9,   0,  1, 0,   0);
    add("oor_ld12s",  0, 1, 1, 1, 1, 12,   9,  12,  0, 0,   0);
    add("oor_sat",    0, 0, 1, 1, 1,  0,   9,   9,  0, 1,   1);
    add("hold_idle",  0, 0, 0, 1, 1,  0,   9,   9,  0, 1,   1);
    // reset overrides load mid-count, then load alone
    add("mid_ld3",    0, 1, 0, 1, 0,  3,   9,   3,  0, 0,   0);
    add("mid_4",      0, 0, 1, 1, 0,  0,   9,   4,  0, 0,   0);
    add("rst_vs_ld",  1, 1, 1, 1, 0,  5,   9,   0,  0, 0,   0);
    add("ld5_after",  0, 1, 0, 1, 0,  5,   9,   5,  0, 0,   0);
    // lim=0 wrap mode: stays at 0 with co every enabled cycle
    add("lim0_a",     0, 0, 1, 1, 0,  0,   0,   0,  1, 0,   1);
    add("lim0_b",     0, 0, 1, 1, 0,  0,   0,   0,  1, 0,   1);
    add("lim0_idle",  0, 0, 0, 1, 0,  0,   0,   0,  0, 0,   1);
    // reset with up=0 reads tc=1
    add("rst_dn_tc",  1, 0, 0, 0, 0,  0,   9,   0,  0, 0,   1);
    // out-of-range downward: plain decrement even in saturate mode
    add("oor_dn_ld",  0, 1, 0, 0, 1, 14,   9,  14,  0, 0,   0);
    add("oor_dn_13",  0, 0, 1, 0, 1,  0,   9,  13,  0, 0,   0);
    add("oor_dn_12",  0, 0, 1, 0, 1,  0,   9,  12,  0, 0,   0);
    // saturate at 0 counting down, then clear by counting up
    add("sdn_ld1",    0, 1, 0, 0, 1,  1,   9,   1,  0, 0,   0);
    add("sdn_0",      0, 0, 1, 0, 1,  0,   9,   0,  0, 0,   1);
    add("sdn_hold",   0, 0, 1, 0, 1,  0,   9,   0,  0, 1,   1);
    add("sdn_up",     0, 0, 1, 1, 1,  0,   9,   1,  0, 0,   0);

    @(negedge clk);
    foreach (vecs[k]) begin
      rst = vecs[k].rst; ld = vecs[k].ld; en = vecs[k].en; up = vecs[k].up;
      sat = vecs[k].sat; initld = vecs[k].initld; lim = vecs[k].lim;
      @(posedge clk);
      @(negedge clk);
      check({vecs[k].name, ".out"},  int'(out),  int'(vecs[k].exp_out));
      check({vecs[k].name, ".co"},   int'(co),   int'(vecs[k].exp_co));
      check({vecs[k].name, ".hold"}, int'(hold), int'(vecs[k].exp_hold));
      check({vecs[k].name, ".tc"},   int'(tc),   int'(vecs[k].exp_tc));
    end

    // N=6 free-running: 64 enabled cycles from 0 return to 0 with one co pulse
    rst6 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("n6_reset.out", int'(out6), 0);
    rst6 = 1'b0; en6 = 1'b1;
    co_pulses = 0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp6 = i % 64;
      check("n6_step.out", int'(out6), exp6);
      if (co6) co_pulses++;
      if (i == 64) check("n6_wrap.co", int'(co6), 1);
    end
    check("n6_co_count", co_pulses, 1);
    en6 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
